// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage MIPS-style pipeline: stalls, flushes, forwarding and mult/div busy tracking.
// Optional performance counters are built when HAZARD_PERFCNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic [4:0]  writeregM,
  input  logic [4:0]  writeregW,
  input  logic        regwriteE,
  input  logic        regwriteM,
  input  logic        regwriteW,
  input  logic        memtoregE,
  input  logic        memtoregM,
  input  logic        branchD,
  input  logic        jumpregD,
  input  logic        PCSrcD,
  input  logic        mdreqD,
  input  logic        mdstartE,
  input  logic        mdopE,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        forwardAD,
  output logic        forwardBD,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        mdbusy,
  output logic [31:0] stallcnt,
  output logic [31:0] flushcnt
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = ($clog2(MAX_LAT + 1) < 5) ? 5 : $clog2(MAX_LAT + 1);

  logic          lwstall;
  logic          brstall;
  logic          mdstall;
  logic          stall;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  logic [4:0] src_d [2];
  logic [4:0] src_e [2];
  logic [1:0] fwd_e [2];
  logic       fwd_d [2];
  logic       dep_e [2];
  logic       dep_m [2];

  assign src_d[0] = rsD;
  assign src_d[1] = rtD;
  assign src_e[0] = rsE;
  assign src_e[1] = rtE;

  // One slice per operand (A = rs, B = rt); $0 never matches anything.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign fwd_e[gi] = (regwriteM && (writeregM != 5'd0) && (writeregM == src_e[gi])) ? 2'b10 :
                         (regwriteW && (writeregW != 5'd0) && (writeregW == src_e[gi])) ? 2'b01 :
                                                                                          2'b00;
      assign fwd_d[gi] = regwriteM && (src_d[gi] != 5'd0) && (writeregM == src_d[gi]);
      assign dep_e[gi] = (writeregE != 5'd0) && (writeregE == src_d[gi]);
      assign dep_m[gi] = (writeregM != 5'd0) && (writeregM == src_d[gi]);
    end
  endgenerate

  assign forwardAE = fwd_e[0];
  assign forwardBE = fwd_e[1];
  assign forwardAD = fwd_d[0];
  assign forwardBD = fwd_d[1];

  assign lwstall = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
  assign brstall = (branchD || jumpregD) &&
                   ((regwriteE && (dep_e[0] || dep_e[1])) ||
                    (memtoregM && (dep_m[0] || dep_m[1])));
  // mdstartE is included so an op issuing this cycle already blocks a dependent D instr.
  assign mdstall = mdreqD && ((cnt_reg != '0) || mdstartE);
  assign stall   = lwstall || brstall || mdstall;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = PCSrcD && !stall;

  always_comb begin
    cnt_next = cnt_reg;
    if (mdstartE) begin
      cnt_next = mdopE ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign mdbusy = (cnt_reg != '0);

`ifdef HAZARD_PERFCNT_EN
  logic [31:0] stallcnt_reg;
  logic [31:0] flushcnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallcnt_reg <= 32'd0;
      flushcnt_reg <= 32'd0;
    end else begin
      if (stall) begin
        stallcnt_reg <= stallcnt_reg + 32'd1;
      end
      if (flushD) begin
        flushcnt_reg <= flushcnt_reg + 32'd1;
      end
    end
  end

  assign stallcnt = stallcnt_reg;
  assign flushcnt = flushcnt_reg;
`else
  assign stallcnt = 32'h0;
  assign flushcnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand sequences, randomized run vs reference model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic        branchD, jumpregD, PCSrcD, mdreqD, mdstartE, mdopE;
  logic        stallF, stallD, flushD, flushE, forwardAD, forwardBD, mdbusy;
  logic [1:0]  forwardAE, forwardBE;
  logic [31:0] stallcnt, flushcnt;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.MULT_LAT(4), .DIV_LAT(16)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jumpregD(jumpregD), .PCSrcD(PCSrcD),
    .mdreqD(mdreqD), .mdstartE(mdstartE), .mdopE(mdopE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdbusy(mdbusy), .stallcnt(stallcnt), .flushcnt(flushcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtrE, mtrM, brD, jrD, pcs, mdreq;
    logic       st, fd;
    logic [1:0] fae, fbe;
    logic       fad, fbd;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_comb(input string tag, input logic st, input logic fd,
                          input logic [1:0] fae, input logic [1:0] fbe,
                          input logic fad, input logic fbd);
    chk({tag, ".stallF"},    32'(stallF),    32'(st));
    chk({tag, ".stallD"},    32'(stallD),    32'(st));
    chk({tag, ".flushE"},    32'(flushE),    32'(st));
    chk({tag, ".flushD"},    32'(flushD),    32'(fd));
    chk({tag, ".forwardAE"}, 32'(forwardAE), 32'(fae));
    chk({tag, ".forwardBE"}, 32'(forwardBE), 32'(fbe));
    chk({tag, ".forwardAD"}, 32'(forwardAD), 32'(fad));
    chk({tag, ".forwardBD"}, 32'(forwardBD), 32'(fbd));
  endtask

  task automatic clr_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    branchD = 0; jumpregD = 0; PCSrcD = 0;
    mdreqD = 0; mdstartE = 0; mdopE = 0;
  endtask

  task automatic apply(input vec_t v);
    rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
    writeregE = v.wE; writeregM = v.wM; writeregW = v.wW;
    regwriteE = v.rwE; regwriteM = v.rwM; regwriteW = v.rwW;
    memtoregE = v.mtrE; memtoregM = v.mtrM;
    branchD = v.brD; jumpregD = v.jrD; PCSrcD = v.pcs;
    mdreqD = v.mdreq; mdstartE = 0; mdopE = 0;
  endtask

  // Reference rules, stated directly from the hazard definitions.
  function automatic bit reads(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
    return (r != 0) && (r == a || r == b);
  endfunction

  function automatic logic [1:0] ref_fwd_e(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (regwriteM && writeregM == src) return 2'b10;
    if (regwriteW && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_stall(input int md_left);
    bit lw, br, md;
    lw = memtoregE && reads(rtE, rsD, rtD);
    br = (branchD || jumpregD) &&
         ((regwriteE && reads(writeregE, rsD, rtD)) || (memtoregM && reads(writeregM, rsD, rtD)));
    md = mdreqD && (md_left > 0 || mdstartE);
    return lw || br || md;
  endfunction

  logic [31:0] exp_cnt;
  int busy_n, stall_n;
  int md_left;
  longint unsigned m_scnt, m_fcnt;
  bit e_st, e_fd;

  initial begin
    clr_inputs();
    //            rsD rtD rsE rtE wE wM wW  rwE rwM rwW mtE mtM brD jrD pcs mdq  st fd fae fbe fad fbd
    tbl[0]  = '{  0,  0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0};
    tbl[1]  = '{  8,  0,  0,  8, 8, 0, 0,  1,  0,  0,  1,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0};
    tbl[2]  = '{  0,  0,  0,  0, 0, 0, 0,  1,  0,  0,  1,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0};
    tbl[3]  = '{  3,  8,  0,  8, 8, 0, 0,  1,  0,  0,  1,  0,  0,  0,  0,  0,   1, 0, 0,  0,  0,  0};
    tbl[4]  = '{  0,  0,  5,  0, 0, 5, 5,  0,  1,  1,  0,  0,  0,  0,  0,  0,   0, 0, 2,  0,  0,  0};
    tbl[5]  = '{  0,  0,  5,  0, 0, 0, 5,  0,  1,  1,  0,  0,  0,  0,  0,  0,   0, 0, 1,  0,  0,  0};
    tbl[6]  = '{  0,  0,  0,  0, 0, 0, 0,  0,  1,  1,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0};
    tbl[7]  = '{  0,  0,  6,  7, 0, 6, 7,  0,  1,  1,  0,  0,  0,  0,  0,  0,   0, 0, 2,  1,  0,  0};
    tbl[8]  = '{  9,  0,  0,  0, 9, 0, 0,  1,  0,  0,  0,  0,  1,  0,  1,  0,   1, 0, 0,  0,  0,  0};
    tbl[9]  = '{  9,  0,  0,  0, 0, 9, 0,  0,  1,  0,  0,  0,  1,  0,  1,  0,   0, 1, 0,  0,  1,  0};
    tbl[10] = '{  4,  0,  0,  0, 0, 4, 0,  0,  1,  0,  0,  1,  0,  1,  1,  0,   1, 0, 0,  0,  1,  0};
    tbl[11] = '{  0,  0,  0,  0, 0, 0, 0,  1,  0,  0,  0,  0,  1,  0,  1,  0,   0, 1, 0,  0,  0,  0};
    tbl[12] = '{  9,  0,  0,  0, 9, 0, 0,  0,  0,  0,  0,  0,  1,  0,  0,  0,   0, 0, 0,  0,  0,  0};
    tbl[13] = '{  0,  3,  0,  0, 3, 0, 0,  1,  0,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  0};
    tbl[14] = '{  0, 12,  0,  0, 0,12, 0,  0,  1,  0,  0,  0,  0,  0,  0,  0,   0, 0, 0,  0,  0,  1};
    tbl[15] = '{  0,  0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  1,   0, 0, 0,  0,  0,  0};
    tbl[16] = '{  0,  0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  1,  1,  0,  1,  0,   0, 1, 0,  0,  0,  0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.mdbusy",   32'(mdbusy), 32'd0);
    chk("reset.stallcnt", stallcnt,    32'd0);
    chk("reset.flushcnt", flushcnt,    32'd0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;

    // Combinational vector table
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk_comb($sformatf("vec%0d", i), tbl[i].st, tbl[i].fd, tbl[i].fae, tbl[i].fbe, tbl[i].fad, tbl[i].fbd);
      $display("txn vec%0d stallD=%b flushD=%b fAE=%b fBE=%b fAD=%b fBD=%b",
               i, stallD, flushD, forwardAE, forwardBE, forwardAD, forwardBD);
      @(posedge clk); #1;
    end
    clr_inputs();

    // Load-use: stall one cycle, then M-to-E forward
    memtoregE = 1; rtE = 8; regwriteE = 1; writeregE = 8; rsD = 8;
    @(negedge clk);
    chk_comb("lwuse.c1", 1, 0, 2'b00, 2'b00, 0, 0);
    @(posedge clk); #1;
    clr_inputs();
    rsE = 8; memtoregM = 1; regwriteM = 1; writeregM = 8;
    @(negedge clk);
    chk_comb("lwuse.c2", 0, 0, 2'b10, 2'b00, 0, 0);
    $display("txn lwuse stallD=%b forwardAE=%b", stallD, forwardAE);
    @(posedge clk); #1;
    clr_inputs();

    // Taken beq depending on an ALU result in E
    branchD = 1; PCSrcD = 1; rsD = 9; regwriteE = 1; writeregE = 9;
    @(negedge clk);
    chk_comb("beq.c1", 1, 0, 2'b00, 2'b00, 0, 0);
    @(posedge clk); #1;
    regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 9;
    @(negedge clk);
    chk_comb("beq.c2", 0, 1, 2'b00, 2'b00, 1, 0);
    $display("txn beq stallD=%b flushD=%b forwardAD=%b", stallD, flushD, forwardAD);
    @(posedge clk); #1;
    clr_inputs();

    // div issue with dependent mflo in D
    mdstartE = 1; mdopE = 1; mdreqD = 1;
    @(negedge clk);
    chk("div.issue.stallD", 32'(stallD), 32'd1);
    chk("div.issue.mdbusy", 32'(mdbusy), 32'd0);
    @(posedge clk); #1;
    mdstartE = 0;
    busy_n = 0; stall_n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mdbusy) busy_n++;
      if (stallD) stall_n++;
      chk($sformatf("div.c%0d.stall_tracks_busy", i), 32'(stallD), 32'(mdbusy));
      @(posedge clk); #1;
    end
    chk("div.busy_cycles",  busy_n,  32'd16);
    chk("div.stall_cycles", stall_n, 32'd17);
    $display("txn div busy_cycles=%0d stall_cycles=%0d", busy_n, stall_n);
    clr_inputs();

    // Reset in the middle of a div (cnt=7)
    mdstartE = 1; mdopE = 1;
    @(posedge clk); #1;
    mdstartE = 0;
    repeat (9) @(posedge clk);
    #1;
    chk("rstmid.busy_before", 32'(mdbusy), 32'd1);
    rst = 1;
    #1;
    chk("rstmid.mdbusy",   32'(mdbusy), 32'd0);
    chk("rstmid.stallcnt", stallcnt,    32'd0);
    chk("rstmid.flushcnt", flushcnt,    32'd0);
    mdreqD = 1;
    #1 chk("rstmid.mdstall_idle", 32'(stallD), 32'd0);
    mdstartE = 1;
    #1 chk("rstmid.mdstall_start", 32'(stallD), 32'd1);
    clr_inputs();
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    chk("rstmid.after_release", 32'(mdbusy), 32'd0);
    memtoregE = 1; rtE = 8; rsD = 8;
    repeat (3) @(posedge clk);
    #1;
    clr_inputs();
`ifdef HAZARD_PERFCNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    chk("rstmid.stallcnt3", stallcnt, exp_cnt);
    chk("rstmid.flushcnt0", flushcnt, 32'd0);
    $display("txn rstmid stallcnt=%0d", stallcnt);

`ifdef HAZARD_PERFCNT_EN
    // Counter wrap
    memtoregE = 1; rtE = 8; rsD = 8;
    force dut.stallcnt_reg = 32'hFFFF_FFFF;
    #1 release dut.stallcnt_reg;
    #1 chk("wrap.preset", stallcnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    clr_inputs();
    chk("wrap.stallcnt", stallcnt, 32'h0);
    $display("txn wrap stallcnt=%h", stallcnt);
`endif

    // Randomized run against the reference model
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    md_left = 0; m_scnt = 0; m_fcnt = 0;
    for (int it = 0; it < 400; it++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
      branchD = ($urandom_range(0, 3) == 0); jumpregD = ($urandom_range(0, 7) == 0);
      PCSrcD = 1'($urandom); mdreqD = 1'($urandom);
      mdstartE = ($urandom_range(0, 11) == 0); mdopE = 1'($urandom);
      @(negedge clk);
      e_st = ref_stall(md_left);
      e_fd = PCSrcD && !e_st;
      chk_comb($sformatf("rnd%0d", it), e_st, e_fd, ref_fwd_e(rsE), ref_fwd_e(rtE),
               regwriteM && rsD != 0 && writeregM == rsD,
               regwriteM && rtD != 0 && writeregM == rtD);
      chk($sformatf("rnd%0d.mdbusy", it), 32'(mdbusy), 32'(md_left > 0));
`ifdef HAZARD_PERFCNT_EN
      chk($sformatf("rnd%0d.stallcnt", it), stallcnt, 32'(m_scnt));
      chk($sformatf("rnd%0d.flushcnt", it), flushcnt, 32'(m_fcnt));
`else
      chk($sformatf("rnd%0d.stallcnt", it), stallcnt, 32'd0);
      chk($sformatf("rnd%0d.flushcnt", it), flushcnt, 32'd0);
`endif
      $display("txn rnd%0d stallD=%b flushD=%b mdbusy=%b left=%0d", it, stallD, flushD, mdbusy, md_left);
      if (mdstartE) md_left = mdopE ? 16 : 4;
      else if (md_left > 0) md_left--;
      if (e_st) m_scnt++;
      if (e_fd) m_fcnt++;
      @(posedge clk); #1;
    end
    clr_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
